// File: rtl/r_engine.sv
// R-channel read-data stage: meters AR issue by outstanding-burst credit, checks burst framing
// and forwards beats through a 2-entry skid buffer. Optional macro: R_ENGINE_RRESP_CHECK_EN.
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | issuing credit, accepting R beats
// FLUSH   | R closed, draining skid buffer before done
module r_engine #(
    parameter int AXI_DATA_WIDTH  = 128,
    parameter int BTT_WIDTH       = 24,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [BTT_WIDTH-1:0]      btt,
    input  logic                      new_transaction,
    input  logic [7:0]                arlen,
    output logic                      ar_enable,
    input  logic                      rvalid,
    output logic                      rready,
    input  logic [AXI_DATA_WIDTH-1:0] rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [AXI_DATA_WIDTH-1:0] out_data,
    output logic                      out_last,
    output logic                      done,
    output logic                      error
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int BW = BTT_WIDTH - 4;
    localparam logic [PW:0] OUT_MAX = (PW+1)'(MAX_OUTSTANDING);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [BW-1:0]             beats_left_q, beats_left_d;
    logic [7:0]                len_mem_q [MAX_OUTSTANDING];
    logic [PW-1:0]             len_rd_q, len_rd_d, len_wr_q, len_wr_d;
    logic [PW:0]               len_cnt_q, len_cnt_d;
    logic [7:0]                burst_beat_q, burst_beat_d;
    logic [AXI_DATA_WIDTH-1:0] skid_data_q [2];
    logic [1:0]                skid_last_q;
    logic                      skid_rd_q, skid_rd_d;
    logic [1:0]                skid_cnt_q, skid_cnt_d;
    logic                      done_q, done_d, error_q, error_d;
    logic                      r_hs, have_len, len_push, len_pop, fwd, pop_out, skid_wr;

    // Outstanding-burst count is the length FIFO occupancy.
    assign ar_enable = (state_q == S_RUN) && (len_cnt_q < OUT_MAX);
    assign rready    = (state_q == S_RUN) && (skid_cnt_q != 2'd2);
    assign r_hs      = rvalid && rready;
    assign have_len  = (len_cnt_q != '0);
    assign len_push  = (state_q == S_RUN) && new_transaction && (len_cnt_q != OUT_MAX);
    assign len_pop   = r_hs && have_len && rlast;
    assign fwd       = r_hs && have_len && (beats_left_q != '0);
    assign out_valid = (skid_cnt_q != 2'd0);
    assign pop_out   = out_valid && out_ready;
    assign out_data  = skid_data_q[skid_rd_q];
    assign out_last  = skid_last_q[skid_rd_q];
    assign skid_wr   = skid_rd_q ^ skid_cnt_q[0];
    assign done      = done_q;
    assign error     = error_q;

`ifndef R_ENGINE_RRESP_CHECK_EN
    logic unused_rresp;
    assign unused_rresp = ^rresp;
`endif
    logic unused_btt_lsb;
    assign unused_btt_lsb = ^btt[3:0];

    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        burst_beat_d = burst_beat_q;
        done_d       = 1'b0;
        error_d      = error_q;
        len_rd_d     = len_rd_q + PW'(len_pop);
        len_wr_d     = len_wr_q + PW'(len_push);
        skid_rd_d    = skid_rd_q ^ pop_out;

        case ({len_push, len_pop})
            2'b10:   len_cnt_d = len_cnt_q + 1'b1;
            2'b01:   len_cnt_d = len_cnt_q - 1'b1;
            default: len_cnt_d = len_cnt_q;
        endcase
        case ({fwd, pop_out})
            2'b10:   skid_cnt_d = skid_cnt_q + 1'b1;
            2'b01:   skid_cnt_d = skid_cnt_q - 1'b1;
            default: skid_cnt_d = skid_cnt_q;
        endcase

        if ((state_q == S_RUN) && new_transaction && (len_cnt_q == OUT_MAX))
            error_d = 1'b1;

        if (r_hs) begin
            if (!have_len || (beats_left_q == '0))
                error_d = 1'b1;
            // Framing is checked even for over-count beats so the burst still closes on rlast.
            if (have_len) begin
                if (rlast != (burst_beat_q == len_mem_q[len_rd_q]))
                    error_d = 1'b1;
                burst_beat_d = rlast ? 8'd0 : burst_beat_q + 8'd1;
            end
`ifdef R_ENGINE_RRESP_CHECK_EN
            if (rresp != 2'b00)
                error_d = 1'b1;
`endif
            if (fwd)
                beats_left_d = beats_left_q - 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_d      = 1'b0;
                    burst_beat_d = 8'd0;
                    if (btt[BTT_WIDTH-1:4] == '0) begin
                        done_d = 1'b1;
                    end else begin
                        beats_left_d = btt[BTT_WIDTH-1:4];
                        state_d      = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if ((beats_left_d == '0) && (len_cnt_d == '0))
                    state_d = S_FLUSH;
            end
            S_FLUSH: begin
                // Done lands the cycle after the final beat leaves the buffer.
                if (skid_cnt_d == 2'd0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            beats_left_q <= '0;
            len_rd_q     <= '0;
            len_wr_q     <= '0;
            len_cnt_q    <= '0;
            burst_beat_q <= '0;
            skid_rd_q    <= 1'b0;
            skid_cnt_q   <= '0;
            skid_last_q  <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) len_mem_q[i] <= '0;
            for (int i = 0; i < 2; i++) skid_data_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            len_rd_q     <= len_rd_d;
            len_wr_q     <= len_wr_d;
            len_cnt_q    <= len_cnt_d;
            burst_beat_q <= burst_beat_d;
            skid_rd_q    <= skid_rd_d;
            skid_cnt_q   <= skid_cnt_d;
            done_q       <= done_d;
            error_q      <= error_d;
            if (len_push)
                len_mem_q[len_wr_q] <= arlen;
            if (fwd) begin
                skid_data_q[skid_wr] <= rdata;
                skid_last_q[skid_wr] <= (beats_left_q == BW'(1));
            end
        end
    end
endmodule

// File: tb/tb_r_engine.sv
// Scoreboard bench for r_engine: directed scenarios plus randomized transfers; expected
// beats are queued when the R handshake is seen and popped by an independent output monitor.
module tb_r_engine;
    localparam int DW = 128;
    localparam int BW = 24;
`ifdef R_ENGINE_RRESP_CHECK_EN
    localparam logic EXP_RRESP_ERR = 1'b1;
`else
    localparam logic EXP_RRESP_ERR = 1'b0;
`endif

    logic          clk = 1'b0, rstn = 1'b0, start = 1'b0;
    logic [BW-1:0] btt = '0;
    logic          new_transaction = 1'b0;
    logic [7:0]    arlen = '0;
    logic          ar_enable, rready;
    logic          rvalid = 1'b0, rlast = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic [1:0]    rresp = '0;
    logic          out_valid, out_last, done, error;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;

    r_engine dut (
        .clk(clk), .rstn(rstn), .start(start), .btt(btt),
        .new_transaction(new_transaction), .arlen(arlen), .ar_enable(ar_enable),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_fail = 0;
    int cyc = 0, last_out_cyc = 0, done_cyc = 0;
    int rdy_mode = 1;          // 0 = hold low, 1 = hold high, 2 = random
    int issued_n = 0;
    logic [DW:0]   exp_q[$];
    logic [DW:0]   exp_e;
    logic          stall_q = 1'b0;
    logic [DW-1:0] stall_data = '0;
    logic [7:0]    lens[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(3) != 0);
        endcase
    end

    // Output monitor: stability under back-pressure and in-order scoreboard compare.
    initial forever begin
        @(negedge clk);
        if (rstn) begin
            if (stall_q) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, stall_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got beat %0h, expected no beat", out_data);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("out_data", out_data, exp_e[DW-1:0]);
                    chk("out_last", out_last, exp_e[DW]);
                    if (out_last) last_out_cyc = cyc;
                end
            end
            stall_q    = out_valid && !out_ready;
            stall_data = out_data;
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic do_start(input int bytes);
        start = 1'b1;
        btt   = BW'(bytes);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(input logic [7:0] len);
        for (int k = 0; k < 300 && !ar_enable; k++) @(negedge clk);
        if (!ar_enable) begin
            n_vec++;
            n_fail++;
            $display("FAIL issue_timeout: ar_enable got 0 expected 1");
        end else begin
            new_transaction = 1'b1;
            arlen           = len;
            @(negedge clk);
            new_transaction = 1'b0;
        end
        issued_n++;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic l, input logic [1:0] resp,
                        input logic fwd, input logic olast);
        rvalid = 1'b1;
        rdata  = d;
        rlast  = l;
        rresp  = resp;
        for (int k = 0; k < 500 && !rready; k++) @(negedge clk);
        if (!rready) begin
            n_vec++;
            n_fail++;
            $display("FAIL beat_timeout: rready got 0 expected 1");
        end else if (fwd) begin
            exp_q.push_back({olast, d});
        end
        @(negedge clk);
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 3000 && !done; k++) @(negedge clk);
        done_cyc = cyc;
        chk(name, done, 1);
        if (done) begin
            @(negedge clk);
            chk({name, "_width"}, done, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d0, d1;
        int nb, rem, idx;

        repeat (3) @(negedge clk);
        chk("rst_ar_enable", ar_enable, 0);
        chk("rst_rready", rready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Single 4-beat burst, free-flowing output.
        rdy_mode = 1;
        do_start(64);
        issue(8'd3);
        for (int i = 0; i < 4; i++) beat(rnd(), i == 3, 2'b00, 1'b1, i == 3);
        wait_done("t1_done");
        chk("t1_done_latency", done_cyc - last_out_cyc, 1);
        chk("t1_error", error, 0);

        // Credit limit: four 16-beat bursts with R withheld.
        rdy_mode = 2;
        do_start(1024);
        for (int b = 0; b < 4; b++) issue(8'd15);
        chk("t2_ar_en_full", ar_enable, 0);
        for (int i = 0; i < 15; i++) beat(rnd(), 1'b0, 2'b00, 1'b1, 1'b0);
        chk("t2_ar_en_hold", ar_enable, 0);
        beat(rnd(), 1'b1, 2'b00, 1'b1, 1'b0);
        chk("t2_ar_en_rise", ar_enable, 1);
        for (int i = 16; i < 64; i++) beat(rnd(), (i % 16) == 15, 2'b00, 1'b1, i == 63);
        wait_done("t2_done");
        chk("t2_error", error, 0);

        // Back-pressure fills the skid buffer.
        rdy_mode = 0;
        do_start(32);
        issue(8'd1);
        d0 = rnd();
        d1 = rnd();
        beat(d0, 1'b0, 2'b00, 1'b1, 1'b0);
        beat(d1, 1'b1, 2'b00, 1'b1, 1'b1);
        chk("t3_rready_low", rready, 0);
        repeat (3) @(negedge clk);
        chk("t3_valid_held", out_valid, 1);
        chk("t3_head_data", out_data, d0);
        rdy_mode = 1;
        wait_done("t3_done");
        chk("t3_drained", exp_q.size(), 0);

        // Early rlast is a framing error that stays until the next start.
        do_start(32);
        issue(8'd1);
        beat(rnd(), 1'b1, 2'b00, 1'b1, 1'b0);
        chk("t4_error_set", error, 1);
        issue(8'd0);
        beat(rnd(), 1'b1, 2'b00, 1'b1, 1'b1);
        wait_done("t4_done");
        chk("t4_error_sticky", error, 1);

        // Push and rlast-pop on the same cycle leave the credit count unchanged.
        do_start(128);
        chk("t5_error_cleared", error, 0);
        issue(8'd1);
        issue(8'd1);
        beat(rnd(), 1'b0, 2'b00, 1'b1, 1'b0);
        chk("t5_rready", rready, 1);
        d1 = rnd();
        new_transaction = 1'b1;
        arlen           = 8'd1;
        rvalid          = 1'b1;
        rdata           = d1;
        rlast           = 1'b1;
        exp_q.push_back({1'b0, d1});
        @(negedge clk);
        new_transaction = 1'b0;
        rvalid          = 1'b0;
        rlast           = 1'b0;
        chk("t5_ar_en_after", ar_enable, 1);
        issue(8'd1);
        chk("t5_ar_en_three", ar_enable, 1);
        for (int i = 2; i < 8; i++) beat(rnd(), (i % 2) == 1, 2'b00, 1'b1, i == 7);
        wait_done("t5_done");
        chk("t5_error", error, 0);

        // Non-OKAY response: forwarded either way, flagged only with the check enabled.
        do_start(16);
        issue(8'd0);
        beat(rnd(), 1'b1, 2'b10, 1'b1, 1'b1);
        chk("t6_rresp_error", error, EXP_RRESP_ERR);
        wait_done("t6_done");

        // Reset mid-transfer discards buffered data.
        rdy_mode = 0;
        do_start(64);
        issue(8'd3);
        beat(rnd(), 1'b0, 2'b00, 1'b1, 1'b0);
        rstn = 1'b0;
        @(negedge clk);
        chk("t7_out_valid", out_valid, 0);
        chk("t7_rready", rready, 0);
        chk("t7_ar_enable", ar_enable, 0);
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        rdy_mode = 1;
        @(negedge clk);

        // Randomized transfers with random burst lengths, gaps and back-pressure.
        rdy_mode = 2;
        for (int t = 0; t < 6; t++) begin
            nb  = $urandom_range(1, 40);
            rem = nb;
            lens.delete();
            while (rem > 0) begin
                int l;
                l = $urandom_range(1, (rem < 16) ? rem : 16);
                lens.push_back(8'(l - 1));
                rem -= l;
            end
            do_start(nb * 16);
            issued_n = 0;
            fork
                begin
                    for (int b = 0; b < lens.size(); b++) begin
                        repeat ($urandom_range(0, 2)) @(negedge clk);
                        issue(lens[b]);
                    end
                end
                begin
                    idx = 0;
                    for (int b = 0; b < lens.size(); b++) begin
                        for (int k = 0; k < 1000 && issued_n <= b; k++) @(negedge clk);
                        for (int j = 0; j <= int'(lens[b]); j++) begin
                            repeat ($urandom_range(0, 1)) @(negedge clk);
                            beat(rnd(), j == int'(lens[b]), 2'b00, 1'b1, idx == nb - 1);
                            idx++;
                        end
                    end
                end
            join
            wait_done("rand_done");
            chk("rand_error", error, 0);
        end

        repeat (4) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
